// File: rtl/rib_rr.sv
// rib_rr: round-robin bus interconnect, MST_NUM masters to SLV_NUM slaves.
// The winning master keeps the bus for up to HOLD_MAX consecutive cycles;
// the pointer then moves past it so every requester is eventually served.
// Slave select comes from the top SEL_W address bits; read data is combinational.
// Optional feature macro: RIB_ERR_EN (registered decode-error pulse and address).
module rib_rr #(
    parameter int MST_NUM  = 4,
    parameter int SLV_NUM  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 4,
    parameter int HOLD_MAX = 8,
    localparam int MW      = $clog2(MST_NUM),
    localparam int HW      = $clog2(HOLD_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MST_NUM-1:0]        i_m_vld,
    input  logic [MST_NUM*ADDR_W-1:0] i_m_addr,
    input  logic [MST_NUM-1:0]        i_m_wr_en,
    input  logic [MST_NUM*DATA_W-1:0] i_m_wr_data,
    output logic [MST_NUM*DATA_W-1:0] o_m_rd_data,
    output logic [MST_NUM-1:0]        o_bus_halt,
    output logic [SLV_NUM*ADDR_W-1:0] o_s_addr,
    output logic [SLV_NUM-1:0]        o_s_wr_en,
    output logic [SLV_NUM*DATA_W-1:0] o_s_wr_data,
    input  logic [SLV_NUM*DATA_W-1:0] i_s_rd_data,
    output logic                      o_gnt_vld,
    output logic [MW-1:0]             o_gnt_id,
    output logic                      o_err_vld,
    output logic [ADDR_W-1:0]         o_err_addr
);

    typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   own_q, own_d;
    logic [MW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic            rr_found;
    logic [MW-1:0]   rr_win;
    logic            own_vld;
    logic [MW-1:0]   own_id;
    logic [ADDR_W-1:0] own_addr;
    logic            own_wr_en;
    logic [DATA_W-1:0] own_wr_data;
    logic [SEL_W-1:0] sel;
    logic            sel_ok;
    logic            unmapped;
    logic [DATA_W-1:0] rd_mux;

    // Pointer increment wrapping at MST_NUM (also for non-power-of-2 counts)
    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] v);
        return (int'(v) == MST_NUM - 1) ? '0 : v + 1'b1;
    endfunction

    // State register: asynchronous reset drops any lock immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Round-robin scan: first requester at or after ptr_q, modulo MST_NUM
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 0; k < MST_NUM; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= MST_NUM) idx = idx - MST_NUM;
            if (!rr_found && i_m_vld[idx]) begin
                rr_found = 1'b1;
                rr_win   = MW'(idx);
            end
        end
    end

    // Next-state logic: slot length counted in hold_q, pointer moves past owner
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    if (HOLD_MAX > 1) begin
                        state_d = S_LOCK;
                        own_d   = rr_win;
                        hold_d  = HW'(1);
                    end else begin
                        ptr_d = wrap_inc(rr_win);
                    end
                end
            end
            S_LOCK: begin
                if (i_m_vld[own_q] && (hold_q < HW'(HOLD_MAX - 1))) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    // Slot used up, or owner let go (the single dead cycle)
                    state_d = S_IDLE;
                    ptr_d   = wrap_inc(own_q);
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: current owner, gated off while reset is held
    always_comb begin
        own_vld = 1'b0;
        own_id  = '0;
        if (rst_n) begin
            if (state_q == S_LOCK) begin
                own_vld = i_m_vld[own_q];
                own_id  = own_q;
            end else begin
                own_vld = rr_found;
                own_id  = rr_win;
            end
        end
    end

    // Owner request fields, muxed out of the flat master buses
    always_comb begin
        own_addr    = '0;
        own_wr_en   = 1'b0;
        own_wr_data = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            if (own_id == MW'(i)) begin
                own_addr    = i_m_addr[i*ADDR_W +: ADDR_W];
                own_wr_en   = i_m_wr_en[i];
                own_wr_data = i_m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel      = own_addr[ADDR_W-1 -: SEL_W];
    assign sel_ok   = own_vld && (int'(sel) < SLV_NUM);
    assign unmapped = own_vld && !sel_ok;

    // Read-data return: unmapped or idle selects read back as zero
    always_comb begin
        rd_mux = '0;
        for (int j = 0; j < SLV_NUM; j++) begin
            if (sel_ok && (sel == SEL_W'(j))) rd_mux = i_s_rd_data[j*DATA_W +: DATA_W];
        end
    end

    assign o_gnt_vld = own_vld;
    assign o_gnt_id  = own_vld ? own_id : '0;

    generate
        for (genvar gi = 0; gi < MST_NUM; gi++) begin : g_mst
            logic is_own;
            assign is_own = own_vld && (own_id == MW'(gi));
            assign o_m_rd_data[gi*DATA_W +: DATA_W] = is_own ? rd_mux : '0;
            assign o_bus_halt[gi] = i_m_vld[gi] & ~is_own;
        end
        for (genvar gi = 0; gi < SLV_NUM; gi++) begin : g_slv
            logic hit;
            assign hit = sel_ok && (sel == SEL_W'(gi));
            assign o_s_addr[gi*ADDR_W +: ADDR_W]    = hit ? own_addr : '0;
            assign o_s_wr_en[gi]                    = hit & own_wr_en;
            assign o_s_wr_data[gi*DATA_W +: DATA_W] = hit ? own_wr_data : '0;
        end
    endgenerate

`ifdef RIB_ERR_EN
    logic              err_vld_q;
    logic [ADDR_W-1:0] err_addr_q;

    // Decode-error capture: one-cycle pulse, address held until the next error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_vld_q <= unmapped;
            if (unmapped) err_addr_q <= own_addr;
        end
    end

    assign o_err_vld  = err_vld_q;
    assign o_err_addr = err_addr_q;
`else
    assign o_err_vld  = 1'b0;
    assign o_err_addr = '0;
`endif

endmodule

// File: tb/tb_rib_rr.sv
// tb_rib_rr: directed and randomized checks of rib_rr against a slot-based
// reference model (owner, cycles used in slot, pointer) kept in the bench.
module tb_rib_rr;
    localparam int N = 4;
    localparam int S = 4;
    localparam int H = 8;
`ifdef RIB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    vld = '0;
    logic [N*32-1:0] m_addr = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*32-1:0] m_wd = '0;
    logic [N*32-1:0] rd_data;
    logic [N-1:0]    halt;
    logic [S*32-1:0] s_addr;
    logic [S-1:0]    s_we;
    logic [S*32-1:0] s_wd;
    logic [S*32-1:0] s_rd = '0;
    logic            gnt_vld;
    logic [1:0]      gnt_id;
    logic            err_vld;
    logic [31:0]     err_addr;

    int checks = 0;
    int errors = 0;

    // Reference model: a slot belongs to one master for at most H owned cycles
    bit          md_lock;
    int          md_own;
    int          md_used;
    int          md_ptr;
    bit          md_err;
    logic [31:0] md_err_addr;

    rib_rr #(.MST_NUM(N), .SLV_NUM(S), .ADDR_W(32), .DATA_W(32), .SEL_W(4), .HOLD_MAX(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m_vld(vld), .i_m_addr(m_addr), .i_m_wr_en(m_we), .i_m_wr_data(m_wd),
        .o_m_rd_data(rd_data), .o_bus_halt(halt),
        .o_s_addr(s_addr), .o_s_wr_en(s_we), .o_s_wr_data(s_wd), .i_s_rd_data(s_rd),
        .o_gnt_vld(gnt_vld), .o_gnt_id(gnt_id), .o_err_vld(err_vld), .o_err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] get_addr(input int i);
        return m_addr[i*32 +: 32];
    endfunction

    function automatic int exp_owner();
        if (md_lock) return vld[md_own] ? md_own : -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (md_ptr + k) % N;
            if (vld[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        md_lock = 1'b0; md_own = 0; md_used = 0; md_ptr = 0;
        md_err = 1'b0; md_err_addr = '0;
    endtask

    task automatic model_tick(input int own);
        logic [31:0] a;
        a = (own >= 0) ? get_addr(own) : 32'h0;
        if (own < 0) begin
            if (md_lock) begin
                md_lock = 1'b0;
                md_ptr  = (md_own + 1) % N;
            end
        end else begin
            if (!md_lock) begin
                md_lock = 1'b1; md_own = own; md_used = 0;
            end
            md_used++;
            if (md_used >= H) begin
                md_lock = 1'b0;
                md_ptr  = (own + 1) % N;
            end
        end
        md_err = ERR_EN && (own >= 0) && (int'(a[31:28]) >= S);
        if (md_err) md_err_addr = a;
    endtask

    task automatic advance(input int own);
        @(posedge clk);
        model_tick(own);
        #1;
    endtask

    task automatic set_m(input int i, input bit v, input logic [31:0] a, input bit we, input logic [31:0] wd);
        vld[i] = v; m_addr[i*32 +: 32] = a; m_we[i] = we; m_wd[i*32 +: 32] = wd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        vld = '0; m_we = '0; rst_n = 1'b0;
        @(negedge clk);
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_gnt_vld: got %b want 0", gnt_vld); end
        checks++; if (halt !== 4'b0) begin errors++; $display("FAIL reset_halt: got %b want 0000", halt); end
        checks++; if (s_we !== 4'b0 || s_addr !== '0) begin errors++; $display("FAIL reset_slave: we=%b addr=%h want 0", s_we, s_addr); end
        checks++; if (err_vld !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_err: vld=%b addr=%h want 0", err_vld, err_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        $display("reset: done");
    endtask

    task automatic test_single_read();
        int e;
        s_rd[32 +: 32] = 32'hA5A5_0001;
        set_m(1, 1'b1, 32'h1000_0010, 1'b0, 32'h0);
        @(negedge clk);
        e = exp_owner();
        checks++; if (rd_data[32 +: 32] !== 32'hA5A5_0001) begin errors++; $display("FAIL read_data: got %h want a5a50001", rd_data[32 +: 32]); end
        checks++; if (halt !== 4'b0) begin errors++; $display("FAIL read_halt: got %b want 0000", halt); end
        checks++; if (gnt_vld !== 1'b1 || gnt_id !== 2'd1) begin errors++; $display("FAIL read_gnt: vld=%b id=%0d want 1/1", gnt_vld, gnt_id); end
        checks++; if (s_addr !== {64'h0, 32'h1000_0010, 32'h0}) begin errors++; $display("FAIL read_saddr: got %h", s_addr); end
        $display("read: m1 addr=10000010 rd=%h", rd_data[32 +: 32]);
        advance(e);
        set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        e = exp_owner();
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL read_release: gnt_vld=%b want 0", gnt_vld); end
        advance(e);
    endtask

    task automatic test_two_masters();
        int e, want;
        vld = '0;
        set_m(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        set_m(2, 1'b1, 32'h2000_0200, 1'b0, 32'h0);
        do_reset();
        for (int c = 0; c < 4 * H; c++) begin
            @(negedge clk);
            e = exp_owner();
            want = ((c / H) % 2 == 0) ? 0 : 2;
            checks++; if (gnt_vld !== 1'b1 || int'(gnt_id) != want) begin errors++; $display("FAIL two_gnt c=%0d: id=%0d vld=%b want %0d", c, gnt_id, gnt_vld, want); end
            checks++; if (halt !== ((want == 0) ? 4'b0100 : 4'b0001)) begin errors++; $display("FAIL two_halt c=%0d: got %b", c, halt); end
            $display("two: c=%0d owner=%0d", c, gnt_id);
            advance(e);
        end
        vld = '0;
    endtask

    task automatic test_all_four();
        int e, want;
        for (int i = 0; i < N; i++) set_m(i, 1'b1, {i[3:0], 28'h000_0040}, 1'b0, 32'h0);
        do_reset();
        for (int c = 0; c < 5 * H; c++) begin
            @(negedge clk);
            e = exp_owner();
            want = (c / H) % N;
            checks++; if (gnt_vld !== 1'b1 || int'(gnt_id) != want) begin errors++; $display("FAIL four_gnt c=%0d: id=%0d want %0d", c, gnt_id, want); end
            $display("four: c=%0d owner=%0d", c, gnt_id);
            advance(e);
        end
        vld = '0;
    endtask

    task automatic test_drop();
        int e;
        vld = '0;
        do_reset();
        set_m(1, 1'b1, 32'h1000_0000, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = exp_owner();
            checks++; if (gnt_id !== 2'd1 || gnt_vld !== 1'b1) begin errors++; $display("FAIL drop_own c=%0d: id=%0d want 1", c, gnt_id); end
            advance(e);
            set_m(3, 1'b1, 32'h3000_0000, 1'b0, 32'h0);
        end
        set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        e = exp_owner();
        checks++; if (gnt_vld !== 1'b0 || halt !== 4'b1000) begin errors++; $display("FAIL drop_dead: vld=%b halt=%b want 0/1000", gnt_vld, halt); end
        $display("drop: dead cycle gnt_vld=%b", gnt_vld);
        advance(e);
        set_m(0, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        @(negedge clk);
        e = exp_owner();
        checks++; if (gnt_vld !== 1'b1 || gnt_id !== 2'd3) begin errors++; $display("FAIL drop_next: id=%0d want 3", gnt_id); end
        checks++; if (halt !== 4'b0001) begin errors++; $display("FAIL drop_halt: got %b want 0001", halt); end
        $display("drop: next owner=%0d", gnt_id);
        advance(e);
        vld = '0;
    endtask

    task automatic test_unmapped();
        int e;
        vld = '0;
        do_reset();
        s_rd = {4{32'h1234_5678}};
        set_m(0, 1'b1, 32'h5000_0000, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        e = exp_owner();
        checks++; if (s_we !== 4'b0 || s_addr !== '0) begin errors++; $display("FAIL unm_strobe: we=%b addr=%h want 0", s_we, s_addr); end
        checks++; if (rd_data !== '0 || halt !== 4'b0 || gnt_vld !== 1'b1) begin errors++; $display("FAIL unm_access: rd=%h halt=%b gnt=%b", rd_data, halt, gnt_vld); end
        $display("unmapped: write 50000000");
        advance(e);
        set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        e = exp_owner();
        checks++; if (err_vld !== ERR_EN) begin errors++; $display("FAIL unm_pulse: got %b want %b", err_vld, ERR_EN); end
        checks++; if (err_addr !== (ERR_EN ? 32'h5000_0000 : 32'h0)) begin errors++; $display("FAIL unm_addr: got %h", err_addr); end
        advance(e);
        @(negedge clk);
        e = exp_owner();
        checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL unm_pulse_end: got %b want 0", err_vld); end
        checks++; if (err_addr !== (ERR_EN ? 32'h5000_0000 : 32'h0)) begin errors++; $display("FAIL unm_addr_hold: got %h", err_addr); end
        advance(e);
    endtask

    task automatic test_reset_midlock();
        int e;
        vld = '0;
        do_reset();
        set_m(2, 1'b1, 32'h2000_0000, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = exp_owner();
            checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL mid_own c=%0d: id=%0d want 2", c, gnt_id); end
            advance(e);
        end
        set_m(0, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        checks++; if (gnt_vld !== 1'b0 || halt !== 4'b0101) begin errors++; $display("FAIL mid_reset: gnt=%b halt=%b want 0/0101", gnt_vld, halt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        e = exp_owner();
        checks++; if (gnt_vld !== 1'b1 || gnt_id !== 2'd0) begin errors++; $display("FAIL mid_after: id=%0d vld=%b want 0/1", gnt_id, gnt_vld); end
        $display("midlock: owner after release=%0d", gnt_id);
        advance(e);
        vld = '0;
    endtask

    task automatic test_random();
        int e, sel;
        logic [31:0]     a;
        logic [N-1:0]    eh;
        logic [N*32-1:0] erd;
        logic [S*32-1:0] esa, ewd;
        logic [S-1:0]    ewe;
        vld = '0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [3:0] top;
                top = 4'($urandom_range(0, 5));
                set_m(i, ($urandom_range(0, 4) != 0), {top, 28'($urandom)}, 1'($urandom), $urandom);
            end
            for (int j = 0; j < S; j++) s_rd[j*32 +: 32] = $urandom;
            @(negedge clk);
            e = exp_owner();
            eh = vld; erd = '0; esa = '0; ewd = '0; ewe = '0;
            if (e >= 0) begin
                eh[e] = 1'b0;
                a = get_addr(e);
                sel = int'(a[31:28]);
                if (sel < S) begin
                    erd[e*32 +: 32] = s_rd[sel*32 +: 32];
                    esa[sel*32 +: 32] = a;
                    ewe[sel] = m_we[e];
                    ewd[sel*32 +: 32] = m_wd[e*32 +: 32];
                end
            end
            checks++; if (gnt_vld !== (e >= 0) || (e >= 0 && int'(gnt_id) != e)) begin errors++; $display("FAIL rnd_gnt c=%0d: vld=%b id=%0d want owner %0d", c, gnt_vld, gnt_id, e); end
            checks++; if (halt !== eh) begin errors++; $display("FAIL rnd_halt c=%0d: got %b want %b", c, halt, eh); end
            checks++; if (rd_data !== erd) begin errors++; $display("FAIL rnd_rd c=%0d: got %h want %h", c, rd_data, erd); end
            checks++; if (s_addr !== esa || s_we !== ewe || s_wd !== ewd) begin errors++; $display("FAIL rnd_slave c=%0d: we=%b want %b addr=%h want %h", c, s_we, ewe, s_addr, esa); end
            checks++; if (err_vld !== md_err || err_addr !== md_err_addr) begin errors++; $display("FAIL rnd_err c=%0d: vld=%b addr=%h want %b %h", c, err_vld, err_addr, md_err, md_err_addr); end
            $display("rand: c=%0d vld=%b owner=%0d", c, vld, e);
            advance(e);
        end
        vld = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_two_masters();
        test_all_four();
        test_drop();
        test_unmapped();
        test_reset_midlock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rib_rr.md
# rib_rr

Parametrised round-robin successor to the SoC's fixed-priority bus interconnect. It connects MST_NUM masters (pipeline IF, pipeline MEM, JTAG DM, …) to SLV_NUM slaves decoded from the top address bits. The winning master is locked for up to HOLD_MAX consecutive cycles, and the round-robin pointer guarantees that no master starves. It sits in `top` between the masters and the memories or peripherals. Slave read data stays combinational, as the existing imem/dmem expect.

## Interface
Parameters:
- MST_NUM, 4: number of masters, 2..8.
- SLV_NUM, 4: number of slaves, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SEL_W, 4: slave-select field width, taken from addr[ADDR_W-1 -: SEL_W]. SLV_NUM ≤ 2^SEL_W.
- HOLD_MAX, 8: maximum consecutive cycles one master may own the bus, ≥ 1.

Ports:
- clk, in, 1: core clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- i_m_vld, in, MST_NUM: per-master request.
- i_m_addr, in, MST_NUM*ADDR_W: master i address at bits [i*ADDR_W +: ADDR_W].
- i_m_wr_en, in, MST_NUM: per-master write enable.
- i_m_wr_data, in, MST_NUM*DATA_W: per-master write data.
- o_m_rd_data, out, MST_NUM*DATA_W: read data, valid only for the owner; 0 for every other master.
- o_bus_halt, out, MST_NUM: master must stall this cycle.
- o_s_addr, out, SLV_NUM*ADDR_W: owner address, full width, sent only to the selected slave; 0 elsewhere.
- o_s_wr_en, out, SLV_NUM: write strobe to the selected slave only.
- o_s_wr_data, out, SLV_NUM*DATA_W: owner write data to the selected slave; 0 elsewhere.
- i_s_rd_data, in, SLV_NUM*DATA_W: slave read data, combinational.
- o_gnt_vld, out, 1: a master owns the bus this cycle.
- o_gnt_id, out, clog2(MST_NUM): owner index.
- o_err_vld, out, 1: decode-error pulse. Exists in both builds; see Configuration.
- o_err_addr, out, ADDR_W: address of the last decode error.

## Operation
Registers:
- state: IDLE or LOCK.
- own_q: owner index, clog2(MST_NUM) bits.
- ptr_q: round-robin pointer, clog2(MST_NUM) bits.
- hold_q: hold counter, clog2(HOLD_MAX+1) bits.

Winner selection:
- rr_win is the first i with i_m_vld[i] set, scanning ptr_q, ptr_q+1, … modulo MST_NUM.

Owner in the current cycle (combinational):
- IDLE: the owner is rr_win if any vld is set, otherwise there is no owner.
- LOCK: the owner is own_q while i_m_vld[own_q]=1.

Bus outputs:
- o_bus_halt[i] = i_m_vld[i] & (i is not the owner).
- o_gnt_vld=1 whenever an owner exists.

Transitions:
- IDLE → LOCK when a winner exists and HOLD_MAX>1. On this edge: own_q←rr_win, hold_q←1.
  - If HOLD_MAX==1, stay in IDLE and set ptr_q←rr_win+1.
- LOCK, owner vld high, hold_q<HOLD_MAX-1: stay in LOCK, hold_q++.
- LOCK, owner vld high, hold_q==HOLD_MAX-1: this is the last owned cycle. Go to IDLE and set ptr_q←own_q+1.
- LOCK, owner vld low: no owner this cycle; go to IDLE and set ptr_q←own_q+1.
  - Other masters get a combinational grant from IDLE on the next cycle.
  - This is the single dead cycle, accepted by design.

Pointer arithmetic: ptr_q+1 wraps modulo MST_NUM, so a non-power-of-2 MST_NUM wraps to 0.

Decode:
- sel = owner addr[ADDR_W-1 -: SEL_W].
- sel ≥ SLV_NUM is unmapped:
  - no slave strobe,
  - owner read data = 0,
  - the write is dropped,
  - the access still completes, with no halt.

Reset, asynchronous:
- state=IDLE, ptr_q=0, own_q=0, hold_q=0, o_err_vld=0, o_err_addr=0.
- Every combinational output is 0 while no vld is asserted.
- A reset in the middle of a lock drops ownership immediately.

## Timing
- Granted access costs 0 extra cycles: address, strobe and read data pass through combinationally in the owner cycle.
- Worst-case wait for a continuously requesting master is (MST_NUM-1)·HOLD_MAX cycles.
- Writes commit at the slave's clk edge in the owner cycle.
- Simultaneous requests in IDLE are resolved by ptr_q alone; there is no fixed priority.
- o_err_vld is registered: it pulses exactly 1 cycle, one cycle after the unmapped owner cycle.

## Configuration
- RIB_ERR_EN defined:
  - Each unmapped owner cycle produces an o_err_vld pulse on the next cycle.
  - o_err_addr captures the offending address and holds it until the next error or reset.
- RIB_ERR_EN undefined:
  - o_err_vld and o_err_addr are tied to 0 and no error registers are built.
  - Decode behaviour (dropped write, read data 0) is identical in both builds.

## Test plan
- Reset, then m1 reads 0x1000_0010 with slave1 rd=0xA5A5_0001 → same cycle: o_m_rd_data[m1]=0xA5A5_0001, o_bus_halt=0, o_gnt_id=1.
- m0 and m2 hold vld continuously from reset, HOLD_MAX=8 → m0 owns 8 cycles, then m2 owns 8 cycles, alternating; the halted master sees o_bus_halt=1 throughout the other's slot.
- All 4 masters request after reset → grant order 0,1,2,3,0, each slot of HOLD_MAX cycles; the pointer wraps from 3 to 0.
- Owner m1 drops vld at hold_q=3 while m3 waits → 1 dead cycle with o_gnt_vld=0, then m3 owns and ptr_q=2.
- With RIB_ERR_EN, owner writes 0x5000_0000 with SLV_NUM=4 → no o_s_wr_en bit set; o_err_vld=1 for the next cycle only; o_err_addr=0x5000_0000.
- rst_n asserted low mid-lock while m2 owns → state=IDLE, o_gnt_vld=0 while rst_n is low; after release with m0 and m2 requesting, m0 wins because ptr_q=0.
